// File: rtl/counter_sweep_controller.sv
// Sweep sequencer for a universal binary counter: load, count up to hi_lim, dwell,
// count down to lo_lim, dwell, for a programmed number of passes, then clear.
module counter_sweep_controller #(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  start_val,
    input  logic [N-1:0]  hi_lim,
    input  logic [N-1:0]  lo_lim,
    input  logic [DW-1:0] dwell,
    input  logic [PW-1:0] passes,
    input  logic [N-1:0]  cnt_q,
    input  logic          cnt_min,
    input  logic          cnt_max,
    output logic [N-1:0]  cnt_data,
    output logic          cnt_load,
    output logic          cnt_en,
    output logic          cnt_up,
    output logic          cnt_syn_clr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DWELL_HI,
        S_DOWN,
        S_DWELL_LO,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  start_val_q, start_val_d;
    logic [N-1:0]  hi_q, hi_d;
    logic [N-1:0]  lo_q, lo_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [PW-1:0] passes_q, passes_d;
    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [PW-1:0] pass_cnt_q, pass_cnt_d;
    logic          abort_q, abort_d;
    logic          cfg_err_q, cfg_err_d;

    logic          cfg_ok;
    logic          up_hit;
    logic          down_hit;
    logic          dwell_last;
    logic          last_pass;
    logic [PW-1:0] pass_target;
    logic [PW-1:0] pass_next;
    logic          abortable;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            start_val_q <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            dwell_q     <= '0;
            passes_q    <= '0;
            dwell_cnt_q <= '0;
            pass_cnt_q  <= '0;
            abort_q     <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_val_q <= start_val_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            dwell_q     <= dwell_d;
            passes_q    <= passes_d;
            dwell_cnt_q <= dwell_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            abort_q     <= abort_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Limit detection also honours the counter's own min/max flags so a bad
    // limit can never let the counter wrap.
    always_comb begin
        cfg_ok      = (lo_lim <= start_val) && (start_val <= hi_lim) && (lo_lim < hi_lim);
        up_hit      = (cnt_q == hi_q) || cnt_max;
        down_hit    = (cnt_q == lo_q) || cnt_min;
        dwell_last  = (dwell_cnt_q == (dwell_q - DW'(1)));
        pass_target = (passes_q == '0) ? PW'(1) : passes_q;
        pass_next   = pass_cnt_q + PW'(1);
        last_pass   = (pass_next >= pass_target);
        abortable   = (state_q == S_LOAD) || (state_q == S_UP) || (state_q == S_DWELL_HI) ||
                      (state_q == S_DOWN) || (state_q == S_DWELL_LO);
    end

    always_comb begin
        state_d     = state_q;
        start_val_d = start_val_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        dwell_d     = dwell_q;
        passes_d    = passes_q;
        dwell_cnt_d = dwell_cnt_q;
        pass_cnt_d  = pass_cnt_q;
        abort_d     = abort_q;
        cfg_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        start_val_d = start_val;
                        hi_d        = hi_lim;
                        lo_d        = lo_lim;
                        dwell_d     = dwell;
                        passes_d    = passes;
                        dwell_cnt_d = '0;
                        pass_cnt_d  = '0;
                        abort_d     = 1'b0;
                        state_d     = S_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_LOAD: state_d = S_UP;
            S_UP: begin
                if (up_hit) begin
                    dwell_cnt_d = '0;
                    state_d     = (dwell_q == '0) ? S_DOWN : S_DWELL_HI;
                end
            end
            S_DWELL_HI: begin
                if (dwell_last) state_d = S_DOWN;
                else            dwell_cnt_d = dwell_cnt_q + DW'(1);
            end
            S_DOWN: begin
                if (down_hit) begin
                    pass_cnt_d  = pass_next;
                    dwell_cnt_d = '0;
                    if (last_pass)          state_d = S_CLEAR;
                    else if (dwell_q == '0) state_d = S_UP;
                    else                    state_d = S_DWELL_LO;
                end
            end
            S_DWELL_LO: begin
                if (dwell_last) state_d = S_UP;
                else            dwell_cnt_d = dwell_cnt_q + DW'(1);
            end
            S_CLEAR: state_d = S_DONE;
            S_DONE: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides any sweep progress; CLEAR/DONE already head home.
        if (abort && abortable) begin
            state_d = S_CLEAR;
            abort_d = 1'b1;
        end
    end

    always_comb begin
        cnt_data    = start_val_q;
        cnt_load    = (state_q == S_LOAD);
        cnt_up      = (state_q == S_UP);
        cnt_en      = ((state_q == S_UP) && !up_hit) || ((state_q == S_DOWN) && !down_hit);
        cnt_syn_clr = (state_q == S_CLEAR);
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE) && !abort_q;
        err         = cfg_err_q || ((state_q == S_DONE) && abort_q);
    end

endmodule

// File: tb/tb_counter_sweep_controller.sv
// Directed bench for counter_sweep_controller driving a behavioural up/down counter.
module tb_counter_sweep_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] start_val;
    logic [7:0] hi_lim;
    logic [7:0] lo_lim;
    logic [7:0] dwell;
    logic [3:0] passes;
    logic [7:0] cnt_data;
    logic       cnt_load;
    logic       cnt_en;
    logic       cnt_up;
    logic       cnt_syn_clr;
    logic       busy;
    logic       done;
    logic       err;

    logic [7:0] q = 8'h00;
    logic       cnt_min;
    logic       cnt_max;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural universal binary counter: syn_clr > load > en.
    always @(posedge clk) begin
        if (cnt_syn_clr)   q <= 8'h00;
        else if (cnt_load) q <= cnt_data;
        else if (cnt_en)   q <= cnt_up ? q + 8'd1 : q - 8'd1;
    end
    assign cnt_min = (q == 8'h00);
    assign cnt_max = (q == 8'hFF);

    counter_sweep_controller #(.N(8), .DW(8), .PW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .start_val   (start_val),
        .hi_lim      (hi_lim),
        .lo_lim      (lo_lim),
        .dwell       (dwell),
        .passes      (passes),
        .cnt_q       (q),
        .cnt_min     (cnt_min),
        .cnt_max     (cnt_max),
        .cnt_data    (cnt_data),
        .cnt_load    (cnt_load),
        .cnt_en      (cnt_en),
        .cnt_up      (cnt_up),
        .cnt_syn_clr (cnt_syn_clr),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {q, load, en, up, clr, busy, done, err}
    function automatic logic [14:0] outs();
        return {q, cnt_load, cnt_en, cnt_up, cnt_syn_clr, busy, done, err};
    endfunction

    task automatic set_cfg(input logic [7:0] sv, input logic [7:0] hi, input logic [7:0] lo,
                           input logic [7:0] dw, input logic [3:0] ps);
        start_val = sv;
        hi_lim    = hi;
        lo_lim    = lo;
        dwell     = dw;
        passes    = ps;
    endtask

    logic [14:0] t2_exp [17] = '{
        {8'd0,  7'b1000100}, {8'd13, 7'b0110100}, {8'd14, 7'b0110100}, {8'd15, 7'b0110100},
        {8'd16, 7'b0010100}, {8'd16, 7'b0000100}, {8'd16, 7'b0000100}, {8'd16, 7'b0100100},
        {8'd15, 7'b0100100}, {8'd14, 7'b0100100}, {8'd13, 7'b0100100}, {8'd12, 7'b0100100},
        {8'd11, 7'b0100100}, {8'd10, 7'b0000100}, {8'd10, 7'b0001100}, {8'd0,  7'b0000110},
        {8'd0,  7'b0000000}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int done_cnt;
        int err_cnt;
        int up_rise;
        int wrap;
        logic prev_up;
        logic found;
        logic [7:0] prevq;

        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        tick();
        tick();
        check_eq("rst_outs", 32'(outs()), 32'(15'd0));
        check_eq("rst_data", 32'(cnt_data), 32'(8'd0));
        reset = 1'b1;
        tick();

        // abort while idle does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("idle_abort", 32'({busy, err, done}), 32'(3'b000));

        // T2: single pass with dwell 2; inputs scrambled after acceptance
        set_cfg(8'd13, 8'd16, 8'd10, 8'd2, 4'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_cfg(8'd99, 8'd0, 8'd200, 8'd0, 4'd7);
        check_eq("t2_c1", 32'(outs()), 32'(t2_exp[0]));
        for (int i = 1; i < 17; i++) begin
            tick();
            check_eq($sformatf("t2_c%0d", i + 1), 32'(outs()), 32'(t2_exp[i]));
        end
        check_eq("t2_data", 32'(cnt_data), 32'(8'd13));

        // T3: three passes, no dwell
        set_cfg(8'd5, 8'd6, 8'd4, 8'd0, 4'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = 0; done_cnt = 0; up_rise = 0; prev_up = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (cnt_up && !prev_up) up_rise++;
            prev_up = cnt_up;
            tick();
        end
        check_eq("t3_busy_cycles", 32'(busy_cnt), 32'(20));
        check_eq("t3_done_pulses", 32'(done_cnt), 32'(1));
        check_eq("t3_excursions", 32'(up_rise), 32'(3));
        check_eq("t3_final_q", 32'(q), 32'(8'd0));

        // T4: bad configs
        set_cfg(8'd20, 8'd16, 8'd10, 8'd0, 4'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t4_err_cycle", 32'({busy, cnt_load, err}), 32'(3'b001));
        check_eq("t4_no_latch", 32'(cnt_data), 32'(8'd5));
        tick();
        check_eq("t4_after", 32'({busy, cnt_load, err}), 32'(3'b000));
        set_cfg(8'd10, 8'd10, 8'd10, 8'd0, 4'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t4b_eq_limits", 32'({busy, cnt_load, err}), 32'(3'b001));
        tick();

        // T5: abort mid-DOWN at q=12
        set_cfg(8'd13, 8'd16, 8'd10, 8'd0, 4'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy && !cnt_up && cnt_en && q == 8'd12) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("t5_reach_q12", 32'(found), 32'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("t5_clear", 32'(outs()), 32'({8'd11, 7'b0001100}));
        tick();
        check_eq("t5_err", 32'(outs()), 32'({8'd0, 7'b0000101}));
        tick();
        check_eq("t5_idle", 32'(outs()), 32'({8'd0, 7'b0000000}));

        // T1: asynchronous reset mid-UP
        set_cfg(8'd20, 8'd40, 8'd10, 8'd0, 4'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cnt_up && q == 8'd25) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("t1_reach_q25", 32'(found), 32'(1));
        #2 reset = 1'b0;
        #1;
        check_eq("t1_outs_now", 32'({cnt_data, cnt_load, cnt_en, cnt_up, cnt_syn_clr, busy, done, err}),
                 32'(15'd0));
        tick();
        tick();
        tick();
        check_eq("t1_q_frozen", 32'(q), 32'(8'd25));
        reset = 1'b1;
        tick();
        check_eq("t1_idle", 32'({busy, done, err}), 32'(3'b000));

        // T6: full-range sweep; start+abort together in IDLE, start again mid-sweep
        set_cfg(8'hFE, 8'hFF, 8'h00, 8'd1, 4'd1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_eq("t6_start_wins", 32'({cnt_load, busy, err}), 32'(3'b110));
        busy_cnt = 0; done_cnt = 0; err_cnt = 0; wrap = 0;
        prevq = q;
        for (int i = 0; i < 300; i++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if ((prevq == 8'hFF && q == 8'h00) || (prevq == 8'h00 && q == 8'hFF)) wrap++;
            prevq = q;
            start = (i == 100);
            tick();
        end
        start = 1'b0;
        check_eq("t6_busy_cycles", 32'(busy_cnt), 32'(262));
        check_eq("t6_done_pulses", 32'(done_cnt), 32'(1));
        check_eq("t6_err_pulses", 32'(err_cnt), 32'(0));
        check_eq("t6_wraps", 32'(wrap), 32'(0));
        check_eq("t6_final_q", 32'(q), 32'(8'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
